// File: rtl/dap_shift_pkg.sv
// Shared definitions for the DAP bit shift sequencer: FSM state encoding and the
// default transfer width.
package dap_shift_pkg;

  localparam int DAP_MAX_BITS = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/dap_shift_sequencer.sv
// Bit-level shift engine for one SWD/JTAG-style transfer, paced by the DAP baud generator.
// Optional feature: define DAP_SHIFT_PARITY_EN to add parity_out / parity_in accumulators.
module dap_shift_sequencer
  import dap_shift_pkg::*;
#(
  parameter int MAX_BITS = DAP_MAX_BITS,
  parameter int CNT_W    = 6
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic                abort,
  input  logic [CNT_W-1:0]    bit_count,
  input  logic                write_dir,
  input  logic [MAX_BITS-1:0] tx_data,
  output logic [MAX_BITS-1:0] rx_data,
  output logic                busy,
  output logic                done,
  output logic                gen_cen,
  input  logic                sclk_pulse,
  input  logic                sclk_delay_pulse,
  output logic                sdo,
  output logic                sdo_oe,
  input  logic                sdi
`ifdef DAP_SHIFT_PARITY_EN
  ,
  output logic                parity_out,
  output logic                parity_in
`endif
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BITS);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t              state, state_nxt;
  logic [MAX_BITS-1:0] tx_shift;
  logic [MAX_BITS-1:0] rx_shift;
  logic [CNT_W-1:0]    bit_cnt;
  logic [CNT_W-1:0]    drv_cnt;
  logic [CNT_W-1:0]    smp_cnt;
  logic [CNT_W-1:0]    bc_clamped;
  logic                wr_dir_q;
  logic                accept;
  logic                drv_fire;
  logic                smp_fire;

  assign bc_clamped = (bit_count > MAX_CNT) ? MAX_CNT : bit_count;
  assign accept     = (state == ST_IDLE) && start && !abort;
  assign drv_fire   = (state == ST_SHIFT) && sclk_pulse;
  // A sample may coincide with the drive that enables it (zero generator delay),
  // but never run ahead of the bits actually driven.
  assign smp_fire   = ((state == ST_SHIFT) || (state == ST_DRAIN)) && sclk_delay_pulse &&
                      (smp_cnt < bit_cnt) && ((smp_cnt < drv_cnt) || drv_fire);

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (accept) state_nxt = (bc_clamped == '0) ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (drv_fire && ((drv_cnt + ONE) == bit_cnt)) state_nxt = ST_DRAIN;
      ST_DRAIN: if (smp_cnt == bit_cnt) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (abort && (state != ST_IDLE)) state_nxt = ST_IDLE;
  end

  // Decoded straight from the state flop so reset removes the generator enable at once.
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);
  assign gen_cen = (state == ST_SHIFT) || (state == ST_DRAIN);
  assign sdo_oe  = wr_dir_q && gen_cen;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      bit_cnt  <= '0;
      drv_cnt  <= '0;
      smp_cnt  <= '0;
      wr_dir_q <= 1'b0;
      sdo      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        tx_shift <= tx_data;
        bit_cnt  <= bc_clamped;
        wr_dir_q <= write_dir;
        drv_cnt  <= '0;
        smp_cnt  <= '0;
        rx_shift <= '0;
      end
      if (drv_fire) begin
        sdo      <= tx_shift[0];
        tx_shift <= tx_shift >> 1;
        drv_cnt  <= drv_cnt + ONE;
      end
      if (smp_fire) begin
        rx_shift <= rx_shift | (MAX_BITS'(sdi) << smp_cnt);
        smp_cnt  <= smp_cnt + ONE;
      end
      if ((state == ST_DRAIN) && (state_nxt == ST_DONE)) rx_data <= rx_shift;
      else if (accept && (bc_clamped == '0)) rx_data <= '0;
      if (state_nxt == ST_IDLE) sdo <= 1'b0;
    end
  end

`ifdef DAP_SHIFT_PARITY_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      parity_out <= 1'b0;
      parity_in  <= 1'b0;
    end else begin
      if (accept) begin
        parity_out <= 1'b0;
        parity_in  <= 1'b0;
      end
      if (drv_fire) parity_out <= parity_out ^ tx_shift[0];
      if (smp_fire) parity_in  <= parity_in ^ sdi;
    end
  end
`endif

endmodule

// File: tb/tb_dap_shift_sequencer.sv
// Directed bench for dap_shift_sequencer with a behavioural baud generator model
// (2-flop enable synchroniser, drive pulse every 4 cycles, sample delay 0 or 2).
module tb_dap_shift_sequencer;

  localparam int MAX_BITS = 32;
  localparam int CNT_W    = 6;

  logic                clk = 1'b0;
  logic                resetn, start, abort, write_dir;
  logic [CNT_W-1:0]    bit_count;
  logic [MAX_BITS-1:0] tx_data, rx_data;
  logic                busy, done, gen_cen, sclk_pulse, sclk_delay_pulse;
  logic                sdo, sdo_oe, sdi;
`ifdef DAP_SHIFT_PARITY_EN
  logic                parity_out, parity_in;
`endif

  int checks   = 0;
  int failures = 0;

  // generator model and sdi source controls
  logic [1:0]  cen_sync;
  logic [1:0]  div_cnt;
  logic [3:0]  dly_line;
  logic        dly0;
  logic [1:0]  sdi_mode;
  logic        sdi_const;
  logic [31:0] pat_word, pat_sh;
  logic [5:0]  pat_cnt;
  logic        pat_clr;

  // observation results
  int          n_done, done_c, nbits;
  logic [31:0] sdo_bits, rx_at_done;
  logic        oe_seen, cen_seen, cen_at_done;

  always #5 clk = ~clk;

  dap_shift_sequencer #(.MAX_BITS(MAX_BITS), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .bit_count(bit_count), .write_dir(write_dir), .tx_data(tx_data),
    .rx_data(rx_data), .busy(busy), .done(done), .gen_cen(gen_cen),
    .sclk_pulse(sclk_pulse), .sclk_delay_pulse(sclk_delay_pulse),
    .sdo(sdo), .sdo_oe(sdo_oe), .sdi(sdi)
`ifdef DAP_SHIFT_PARITY_EN
    , .parity_out(parity_out), .parity_in(parity_in)
`endif
  );

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cen_sync <= 2'b00;
      div_cnt  <= 2'd0;
      dly_line <= 4'd0;
    end else begin
      cen_sync <= {cen_sync[0], gen_cen};
      div_cnt  <= cen_sync[1] ? div_cnt + 2'd1 : 2'd0;
      dly_line <= {dly_line[2:0], sclk_pulse};
    end
  end
  assign sclk_pulse       = cen_sync[1] && (div_cnt == 2'd0);
  assign sclk_delay_pulse = dly0 ? sclk_pulse : dly_line[1];

  always @(posedge clk) begin
    if (pat_clr) pat_cnt <= 6'd0;
    else if (sclk_delay_pulse) pat_cnt <= pat_cnt + 6'd1;
  end
  assign pat_sh = pat_word >> pat_cnt;

  always_comb begin
    case (sdi_mode)
      2'd0:    sdi = sdo;
      2'd1:    sdi = sdi_const;
      default: sdi = pat_sh[0];
    endcase
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic [CNT_W-1:0] bc, input logic [31:0] tx, input logic wd);
    @(negedge clk);
    bit_count = bc; tx_data = tx; write_dir = wd; start = 1'b1;
  endtask

  // Watches one transfer from the negedge after start acceptance (c=0); optionally
  // pulses a conflicting start at cycle poke_c.
  task automatic observe(input int budget, input int poke_c);
    logic prev_sp;
    prev_sp = 1'b0; n_done = 0; done_c = -1; sdo_bits = '0; nbits = 0;
    oe_seen = 1'b0; cen_seen = 1'b0; cen_at_done = 1'b0; rx_at_done = '0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
      if (c == poke_c) begin
        start = 1'b1; bit_count = 6'd8; tx_data = 32'hFFFF_FFFF; write_dir = 1'b1;
      end
      if (c == poke_c + 1) start = 1'b0;
      if (prev_sp && busy && nbits < 32) begin
        sdo_bits = sdo_bits | (32'(sdo) << nbits);
        nbits++;
      end
      oe_seen  = oe_seen | sdo_oe;
      cen_seen = cen_seen | gen_cen;
      if (done) begin
        n_done++;
        if (done_c < 0) begin
          done_c = c; cen_at_done = gen_cen; rx_at_done = rx_data;
        end
      end
      prev_sp = sclk_pulse;
    end
  endtask

  task automatic test_reset;
    idle(2);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (gen_cen !== 1'b0) begin failures++; $display("FAIL reset_gen_cen: got %b expected 0", gen_cen); end
    checks++; if ({sdo, sdo_oe} !== 2'b00) begin failures++; $display("FAIL reset_sdo: got %b expected 00", {sdo, sdo_oe}); end
    checks++; if (rx_data !== 32'h0) begin failures++; $display("FAIL reset_rx: got %h expected 00000000", rx_data); end
    resetn = 1'b1;
    idle(3);
  endtask

  task automatic test_basic;
    sdi_mode = 2'd0; dly0 = 1'b0;
    do_start(6'd8, 32'h0000_00A5, 1'b1);
    observe(40, -1);
    checks++; if (nbits !== 8) begin failures++; $display("FAIL basic_nbits: got %0d expected 8", nbits); end
    checks++; if (sdo_bits !== 32'hA5) begin failures++; $display("FAIL basic_sdo_seq: got %h expected 000000a5", sdo_bits); end
    checks++; if (n_done !== 1) begin failures++; $display("FAIL basic_done_cnt: got %0d expected 1", n_done); end
    checks++; if (done_c !== 34) begin failures++; $display("FAIL basic_done_cycle: got %0d expected 34", done_c); end
    checks++; if (rx_at_done !== 32'h0000_00A5) begin failures++; $display("FAIL basic_rx: got %h expected 000000a5", rx_at_done); end
    checks++; if (oe_seen !== 1'b1) begin failures++; $display("FAIL basic_oe: got %b expected 1", oe_seen); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
    idle(10);
  endtask

  task automatic test_full32_delay0;
    sdi_mode = 2'd2; dly0 = 1'b1; pat_word = 32'hDEAD_BEEF;
    @(negedge clk); pat_clr = 1'b1;
    @(negedge clk); pat_clr = 1'b0;
    do_start(6'd32, 32'hDEAD_BEEF, 1'b1);
    observe(135, -1);
    checks++; if (rx_at_done !== 32'hDEAD_BEEF) begin failures++; $display("FAIL full32_rx: got %h expected deadbeef", rx_at_done); end
    checks++; if (sdo_bits !== 32'hDEAD_BEEF) begin failures++; $display("FAIL full32_sdo_seq: got %h expected deadbeef", sdo_bits); end
    checks++; if (done_c !== 128) begin failures++; $display("FAIL full32_done_cycle: got %0d expected 128", done_c); end
    checks++; if (cen_at_done !== 1'b0) begin failures++; $display("FAIL full32_cen_in_done: got %b expected 0", cen_at_done); end
    dly0 = 1'b0;
    idle(10);
  endtask

  task automatic test_read_only;
    sdi_mode = 2'd1; sdi_const = 1'b1;
    do_start(6'd3, 32'h0000_0005, 1'b0);
    observe(20, -1);
    checks++; if (oe_seen !== 1'b0) begin failures++; $display("FAIL rdonly_oe: got %b expected 0", oe_seen); end
    checks++; if (rx_at_done !== 32'h7) begin failures++; $display("FAIL rdonly_rx: got %h expected 00000007", rx_at_done); end
    checks++; if (done_c !== 14) begin failures++; $display("FAIL rdonly_done_cycle: got %0d expected 14", done_c); end
    sdi_mode = 2'd0;
    idle(10);
  endtask

  task automatic test_abort;
    logic prev_sp, hit;
    int drives, late_dones;
    // abort and start in the same idle cycle: abort wins
    @(negedge clk); bit_count = 6'd4; tx_data = 32'h3; write_dir = 1'b1; start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_start_same: got busy=%b expected 0", busy); end
    idle(3);
    do_start(6'd16, 32'h0000_BEEF, 1'b1);
    prev_sp = 1'b0; hit = 1'b0; drives = 0;
    for (int c = 0; c < 60 && !hit; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
      if (prev_sp && busy) drives++;
      prev_sp = sclk_pulse;
      if (drives == 4) begin abort = 1'b1; hit = 1'b1; end
    end
    checks++; if (hit !== 1'b1) begin failures++; $display("FAIL abort_timeout: got %0d drives expected 4", drives); end
    @(negedge clk); abort = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (gen_cen !== 1'b0) begin failures++; $display("FAIL abort_gen_cen: got %b expected 0", gen_cen); end
    checks++; if ({sdo_oe, done} !== 2'b00) begin failures++; $display("FAIL abort_oe_done: got %b expected 00", {sdo_oe, done}); end
    checks++; if (rx_data !== 32'h7) begin failures++; $display("FAIL abort_rx_kept: got %h expected 00000007", rx_data); end
    late_dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) late_dones++;
    end
    checks++; if (late_dones !== 0) begin failures++; $display("FAIL abort_no_done: got %0d expected 0", late_dones); end
    do_start(6'd4, 32'h0000_0009, 1'b1);
    observe(30, -1);
    checks++; if (rx_at_done !== 32'h9) begin failures++; $display("FAIL abort_restart_rx: got %h expected 00000009", rx_at_done); end
    checks++; if (n_done !== 1) begin failures++; $display("FAIL abort_restart_done: got %0d expected 1", n_done); end
    idle(10);
  endtask

  task automatic test_zero_and_busy_start;
    do_start(6'd0, 32'h0000_00FF, 1'b1);
    observe(6, -1);
    checks++; if (done_c !== 0) begin failures++; $display("FAIL zero_done_cycle: got %0d expected 0", done_c); end
    checks++; if (n_done !== 1) begin failures++; $display("FAIL zero_done_cnt: got %0d expected 1", n_done); end
    checks++; if (cen_seen !== 1'b0) begin failures++; $display("FAIL zero_gen_cen: got %b expected 0", cen_seen); end
    checks++; if (rx_at_done !== 32'h0) begin failures++; $display("FAIL zero_rx: got %h expected 00000000", rx_at_done); end
    idle(3);
    do_start(6'd4, 32'h0000_0003, 1'b1);
    observe(25, 5);
    checks++; if (rx_at_done !== 32'h3) begin failures++; $display("FAIL busystart_rx: got %h expected 00000003", rx_at_done); end
    checks++; if (done_c !== 18) begin failures++; $display("FAIL busystart_done_cycle: got %0d expected 18", done_c); end
    checks++; if (n_done !== 1) begin failures++; $display("FAIL busystart_done_cnt: got %0d expected 1", n_done); end
    idle(10);
  endtask

  task automatic test_clamp;
    do_start(6'd40, 32'h1234_5678, 1'b1);
    observe(140, -1);
    checks++; if (nbits !== 32) begin failures++; $display("FAIL clamp_nbits: got %0d expected 32", nbits); end
    checks++; if (rx_at_done !== 32'h1234_5678) begin failures++; $display("FAIL clamp_rx: got %h expected 12345678", rx_at_done); end
    checks++; if (done_c !== 130) begin failures++; $display("FAIL clamp_done_cycle: got %0d expected 130", done_c); end
    idle(10);
  endtask

  task automatic test_reset_mid;
    do_start(6'd16, 32'h0000_FFFF, 1'b1);
    idle(1); start = 1'b0;
    idle(8);
    checks++; if (gen_cen !== 1'b1) begin failures++; $display("FAIL midreset_pre_cen: got %b expected 1", gen_cen); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (gen_cen !== 1'b0) begin failures++; $display("FAIL midreset_gen_cen: got %b expected 0", gen_cen); end
    checks++; if ({busy, sdo, sdo_oe} !== 3'b000) begin failures++; $display("FAIL midreset_ctrl: got %b expected 000", {busy, sdo, sdo_oe}); end
    checks++; if (rx_data !== 32'h0) begin failures++; $display("FAIL midreset_rx: got %h expected 00000000", rx_data); end
    @(negedge clk); resetn = 1'b1;
    idle(5);
  endtask

`ifdef DAP_SHIFT_PARITY_EN
  task automatic test_parity;
    sdi_mode = 2'd0; dly0 = 1'b0;
    do_start(6'd3, 32'h0000_0007, 1'b1);
    observe(20, -1);
    checks++; if (parity_out !== 1'b1) begin failures++; $display("FAIL parity_out: got %b expected 1", parity_out); end
    checks++; if (parity_in !== 1'b1) begin failures++; $display("FAIL parity_in: got %b expected 1", parity_in); end
    checks++; if (rx_at_done !== 32'h7) begin failures++; $display("FAIL parity_rx: got %h expected 00000007", rx_at_done); end
  endtask
`endif

  initial begin
    resetn = 1'b0; start = 1'b0; abort = 1'b0; bit_count = '0; tx_data = '0; write_dir = 1'b0;
    dly0 = 1'b0; sdi_mode = 2'd0; sdi_const = 1'b0; pat_word = '0; pat_clr = 1'b1;
    test_reset();
    pat_clr = 1'b0;
    test_basic();
    test_full32_delay0();
    test_read_only();
    test_abort();
    test_zero_and_busy_start();
    test_clamp();
    test_reset_mid();
`ifdef DAP_SHIFT_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
